awgn_clt_gauss: RTL
===================

Name: awgn_clt_gauss

Overview:
- Downstream consumer of the 32-bit Tausworthe uniform generator in the AWGN core.
- Sums N_SUM uniform samples (central-limit approximation), removes the mean and scales by a runtime sigma.
- Emits saturated signed Gaussian noise samples on a valid/ready stream toward the LDPC channel-LLR adder.

Parameters:
- UW, 16: bits taken from each uniform word (MSBs, in_u[31:32-UW]).
- N_SUM, 12: uniforms summed per output sample; legal range 2..16.
- SIGMA_W, 16: sigma width, unsigned.
- SIGMA_FRAC, 12: fractional bits of sigma; 0x1000 means 1.0.
- OW, 16: output width, signed two's complement.
- OUT_FRAC, 11: output fractional bits; 1.0 std maps to 2^OUT_FRAC.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_u  in  32  uniform word from the generator
- in_valid  in  1  in_u valid this cycle
- in_ready  out  1  block accepts in_u this cycle
- sigma  in  SIGMA_W  noise std, Q(SIGMA_W-SIGMA_FRAC).SIGMA_FRAC; sampled with the last beat of each group
- out_noise  out  OW  Gaussian sample, signed QX.OUT_FRAC
- out_valid  out  1  out_noise valid
- out_ready  in  1  downstream accepts
- sat_flag  out  1  sticky: at least one output saturated since reset

Behaviour:
- Reset values: clk/reset as already decided (reset reset, synchronous, active-high; clock clk).
  - Reset clears: out_noise=0, out_valid=0, sat_flag=0, accumulator=0, beat count=0, stage-1 valid=0.
  - in_ready may be 1 during reset, but beats presented during reset are discarded.
- Beat acceptance:
  - A beat is accepted on a rising edge where in_valid && in_ready.
  - Bubbles (in_valid=0) leave all state unchanged.
- Accumulator:
  - Width CW = UW + clog2(N_SUM) + 1, signed.
  - Count runs 0..N_SUM-1. Each accepted beat adds u = in_u[31:32-UW], zero-extended.
- Last beat of a group (count == N_SUM-1):
  - centred = acc + u - N_SUM*2^(UW-1), computed combinationally.
  - centred and sigma are registered into stage 1 (s1_valid=1).
  - Accumulator and count are cleared on the same edge.
- Stage 1 to output:
  - p = centred * sigma, signed, CW+SIGMA_W+1 bits.
  - q = p >>> (SIGMA_FRAC + UW - OUT_FRAC): arithmetic shift, truncation toward -inf, no rounding.
  - q is saturated to [-2^(OW-1), 2^(OW-1)-1]. Any clipping sets sat_flag on the load edge.
  - The result loads out_noise with out_valid=1.
- Advance rules:
  - Stage 1 advances (s1_adv) when s1_valid && (!out_valid || out_ready).
  - Output register: loads on s1_adv. Clears out_valid when out_valid && out_ready && !s1_adv.
- Flow control:
  - in_ready = !s1_valid || s1_adv. This is a combinational path from out_ready; it is allowed.
  - Holding all beats while stage 1 is blocked keeps every sample in order and loses none.
- Stability: out_noise is stable while out_valid && !out_ready.
- Latency: Nth beat accepted at edge T → out_valid=1 after edge T+1, with no backpressure.
- Throughput: one output per N_SUM accepted beats. Fully pipelined across groups; no idle cycle between groups.
- Simultaneous events:
  - Last-beat capture and s1_adv on the same edge: stage 1 takes the new sum while the old one moves to the output.
  - Output drain and output load on the same edge: the load wins.
- Reset mid-group: the partial sum is discarded. The next output uses only the N_SUM beats accepted after reset.
- Defaults, for reference: shift = 17; CLT-12 gives std 2^16 in centred; sigma=1.0 maps to std 2048 LSB.

Decomposition:
- Shared package awgn_pkg holds:
  - default UW/N_SUM/OUT_FRAC constants
  - a clog2 function
  - the mean-offset constant function N_SUM*2^(UW-1)
  - a saturate-to-OW function
- One sub-module, awgn_scale_sat: combinational multiply, arithmetic shift and saturate, plus a clip indicator.
- The top module holds the accumulator, count, stage-1 register and handshake.

Test Plan:
1. 12 beats of in_u=0x80000000, sigma=0x1000 → centred=0, out_noise=0, out_valid 2 edges after the 12th beat, sat_flag=0.
2. 12 beats of 0xFFFFFFFF, sigma=0x1000 → centred=393204, out_noise=12287 (0x2FFF).
3. 12 beats of 0x00000000, sigma=0x1000 → centred=-393216, out_noise=-12288 (0xD000).
4. 12 beats of 0xFFFFFFFF, sigma=0xF000 → q=184314, out_noise=32767, sat_flag=1 and stays 1 over later in-range outputs.
5. Backpressure: out_ready=0 after the first output, then stream 36 beats with mixed patterns:
   - in_ready drops once stage 1 is full.
   - On releasing out_ready, outputs emerge in order and match the reference model, with no sample lost or duplicated.
6. Reset and bubbles:
   - 5 beats, then reset for 1 cycle, then 12 beats of 0x80000000 with random in_valid bubbles.
   - Response: exactly one output, value 0, and out_valid=0 throughout reset.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared constants and helpers for the AWGN noise path: default widths,
// ceiling log2, the CLT mean offset and an OW-bit saturator.
package awgn_pkg;

   localparam int UW_DEF       = 16;
   localparam int N_SUM_DEF    = 12;
   localparam int OUT_FRAC_DEF = 11;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Expected value of a sum of n_sum uniforms of uw bits: n_sum * 2^(uw-1).
   function automatic longint mean_offset(input int n_sum, input int uw);
      return longint'(n_sum) <<< (uw - 1);
   endfunction

   function automatic logic signed [63:0] sat_ow(input logic signed [63:0] x, input int ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/awgn_scale_sat.sv
// Combinational sigma scaling: signed multiply, arithmetic right shift
// (floor, no rounding) and saturation to OW bits with a clip indicator.
module awgn_scale_sat
   import awgn_pkg::*;
#(
   parameter int CW      = 21,
   parameter int SIGMA_W = 16,
   parameter int SHIFT   = 17,
   parameter int OW      = 16
) (
   input  logic signed [CW-1:0] centred,
   input  logic [SIGMA_W-1:0]   sigma,
   output logic [OW-1:0]        noise,
   output logic                 clip
);

   localparam int PW = CW + SIGMA_W + 1;

   logic signed [PW-1:0] p;
   logic signed [PW-1:0] q;
   logic signed [63:0]   q64;
   logic signed [63:0]   sat;

   // sigma is unsigned; a zero MSB keeps it positive in the signed product.
   assign p     = PW'(centred) * PW'($signed({1'b0, sigma}));
   assign q     = p >>> SHIFT;
   assign q64   = 64'(q);
   assign sat   = sat_ow(q64, OW);
   assign noise = sat[OW-1:0];
   assign clip  = (sat != q64);

endmodule

// File: rtl/awgn_clt_gauss.sv
// Central-limit Gaussian noise: sums N_SUM uniforms, removes the mean,
// scales by sigma and emits saturated samples on a valid/ready stream.
module awgn_clt_gauss
   import awgn_pkg::*;
#(
   parameter int UW         = UW_DEF,
   parameter int N_SUM      = N_SUM_DEF,
   parameter int SIGMA_W    = 16,
   parameter int SIGMA_FRAC = 12,
   parameter int OW         = 16,
   parameter int OUT_FRAC   = OUT_FRAC_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        in_u,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SIGMA_W-1:0] sigma,
   output logic [OW-1:0]      out_noise,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sat_flag
);

   localparam int CNT_W = (clog2(N_SUM) < 1) ? 1 : clog2(N_SUM);
   localparam int CW    = UW + clog2(N_SUM) + 1;
   localparam int SHIFT = SIGMA_FRAC + UW - OUT_FRAC;
   localparam logic signed [CW-1:0] MEAN = CW'(mean_offset(N_SUM, UW));

   logic [UW-1:0]        u;
   logic                 unused_low_bits;
   logic                 accept;
   logic                 last;
   logic                 s1_adv;
   logic signed [CW-1:0] acc;
   logic [CNT_W-1:0]     count;
   logic signed [CW-1:0] centred;
   logic signed [CW-1:0] s1_centred;
   logic [SIGMA_W-1:0]   s1_sigma;
   logic                 s1_valid;
   logic [OW-1:0]        noise;
   logic                 clip;

   assign u               = in_u[31:32-UW];
   assign unused_low_bits = ^in_u[31-UW:0];

   // Both ports transfer on a rising edge where valid && ready; a producer
   // holds its data stable while valid is high and ready is low.
   assign s1_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s1_adv;
   assign accept   = in_valid && in_ready;
   assign last     = (count == CNT_W'(N_SUM - 1));
   assign centred  = acc + $signed(CW'(u)) - MEAN;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         count      <= '0;
         s1_centred <= '0;
         s1_sigma   <= '0;
         s1_valid   <= 1'b0;
      end else begin
         if (accept) begin
            if (last) begin
               acc        <= '0;
               count      <= '0;
               s1_centred <= centred;
               s1_sigma   <= sigma;
            end else begin
               acc   <= acc + $signed(CW'(u));
               count <= count + CNT_W'(1);
            end
         end
         if (accept && last) s1_valid <= 1'b1;
         else if (s1_adv)    s1_valid <= 1'b0;
      end
   end

   awgn_scale_sat #(
      .CW      (CW),
      .SIGMA_W (SIGMA_W),
      .SHIFT   (SHIFT),
      .OW      (OW)
   ) u_scale_sat (
      .centred (s1_centred),
      .sigma   (s1_sigma),
      .noise   (noise),
      .clip    (clip)
   );

   // A load on the same edge as a drain keeps out_valid high.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_noise <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (s1_adv) begin
         out_noise <= noise;
         out_valid <= 1'b1;
         if (clip) sat_flag <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
